// File: rtl/calc_pkg.sv
// Shared types for the calculator sequencer: FSM states, key indices and
// the decoded key event passed from the pushbutton front end to the FSM.
package calc_pkg;

  typedef enum logic [1:0] {ENTRY_A, ENTRY_B, EXEC, SHOW} state_t;

  localparam int KEY_ADD = 16;
  localparam int KEY_SUB = 17;
  localparam int KEY_EQ  = 18;
  localparam int KEY_CLR = 19;

  typedef enum logic [2:0] {NONE, DIGIT, OP, EQ, CLR} key_kind_t;

  // value carries the hex digit for DIGIT, or 1 = sub / 0 = add for OP
  typedef struct packed {
    key_kind_t  kind;
    logic [3:0] value;
  } key_ev_t;

endpackage

// File: rtl/calc_sequencer_if.sv
// Button, adder and display signals between calc_sequencer and its parent.
// master = the parent (drives buttons and the adder sum), slave = the sequencer.
interface calc_sequencer_if #(parameter int W = 8);
  logic [20:0]  pb;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_ci;
  logic [W-1:0] add_s;
  logic         add_co;
  logic [W-1:0] disp;
  logic         carry;
  logic         ovf;
  logic         busy;
  logic         op_sub;

  modport master (
    output pb, add_s, add_co,
    input  add_a, add_b, add_ci, disp, carry, ovf, busy, op_sub
  );

  modport slave (
    input  pb, add_s, add_co,
    output add_a, add_b, add_ci, disp, carry, ovf, busy, op_sub
  );
endinterface

// File: rtl/pb_edge.sv
// Pushbutton rising-edge detector and priority encoder: one key event per cycle,
// clear > equals > sub > add > lowest digit.
module pb_edge
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [20:0] pb_i,
  output key_ev_t     ev_o
);

  logic [19:0] pb_q;
  logic        armed_q;
  logic [19:0] rise;
  logic        unused_pb;

  assign unused_pb = pb_i[20];

  // armed_q masks the first edge after reset, so a button held through reset
  // must be released and pressed again before it produces an event.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pb_q    <= '0;
      armed_q <= 1'b0;
    end else begin
      pb_q    <= pb_i[19:0];
      armed_q <= 1'b1;
    end
  end

  assign rise = armed_q ? (pb_i[19:0] & ~pb_q) : '0;

  // NOTE: ev_o gets a full default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    ev_o = '{kind: NONE, value: 4'h0};
    if (rise[KEY_CLR]) begin
      ev_o.kind = CLR;
    end else if (rise[KEY_EQ]) begin
      ev_o.kind = EQ;
    end else if (rise[KEY_SUB]) begin
      ev_o = '{kind: OP, value: 4'h1};
    end else if (rise[KEY_ADD]) begin
      ev_o = '{kind: OP, value: 4'h0};
    end else begin
      for (int i = 15; i >= 0; i--) begin
        if (rise[i]) begin
          ev_o.kind  = DIGIT;
          ev_o.value = 4'(i);
        end
      end
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer: collects two hex operands and an operator from key
// events, drives the external adder for one EXEC cycle and registers the result.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int W = 8
) (
  input logic             hz100,
  input logic             reset,
  calc_sequencer_if.slave bus
);

  key_ev_t      key_ev;
  state_t       state_q;
  logic [W-1:0] entry_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         op_sub_q;
  logic [W-1:0] result_q;
  logic         carry_q;
  logic         ovf_q;
  logic [W-1:0] add_b;

  pb_edge u_pb_edge (
    .clk   (hz100),
    .rst_n (reset),
    .pb_i  (bus.pb),
    .ev_o  (key_ev)
  );

  assign add_b = op_sub_q ? ~b_q : b_q;

  // Clear acts like reset on every register here; pb_edge keeps sampling.
  always_ff @(posedge hz100) begin
    if (!reset || key_ev.kind == CLR) begin
      state_q  <= ENTRY_A;
      entry_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_sub_q <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ENTRY_A: begin
          case (key_ev.kind)
            DIGIT: entry_q <= {entry_q[W-5:0], key_ev.value};
            OP: begin
              a_q      <= entry_q;
              op_sub_q <= key_ev.value[0];
              entry_q  <= '0;
              state_q  <= ENTRY_B;
            end
            default: ;
          endcase
        end
        ENTRY_B: begin
          case (key_ev.kind)
            DIGIT: entry_q  <= {entry_q[W-5:0], key_ev.value};
            OP:    op_sub_q <= key_ev.value[0];
            EQ: begin
              b_q     <= entry_q;
              state_q <= EXEC;
            end
            default: ;
          endcase
        end
        EXEC: begin
          // carry holds borrow for sub: the adder carries out exactly when A >= B
          result_q <= bus.add_s;
          carry_q  <= bus.add_co ^ op_sub_q;
          ovf_q    <= (a_q[W-1] == add_b[W-1]) & (bus.add_s[W-1] != a_q[W-1]);
          state_q  <= SHOW;
        end
        SHOW: begin
          case (key_ev.kind)
            DIGIT: begin
              entry_q <= W'(key_ev.value);
              state_q <= ENTRY_A;
            end
            OP: begin
              a_q      <= result_q;
              op_sub_q <= key_ev.value[0];
              entry_q  <= '0;
              state_q  <= ENTRY_B;
            end
            EQ: begin
              a_q     <= result_q;
              state_q <= EXEC;
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  assign bus.add_a  = a_q;
  assign bus.add_b  = add_b;
  assign bus.add_ci = op_sub_q;
  assign bus.disp   = (state_q == ENTRY_A || state_q == ENTRY_B) ? entry_q : result_q;
  assign bus.carry  = carry_q;
  assign bus.ovf    = ovf_q;
  assign bus.busy   = (state_q == EXEC);
  assign bus.op_sub = op_sub_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: stimulus pushes expected outputs into a
// queue; a monitor pops and compares at snapshots and whenever busy falls.
module tb_calc_sequencer;

  localparam int K_ADD = 16;
  localparam int K_SUB = 17;
  localparam int K_EQ  = 18;
  localparam int K_CLR = 19;

  typedef struct {
    string      name;
    logic [7:0] disp;
    logic       carry;
    logic       ovf;
    logic       op_sub;
    bit         chk_add;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_ci;
  } exp_t;

  logic hz100 = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   snap_cnt = 0;
  exp_t exp_q[$];

  calc_sequencer_if #(.W(8)) bus ();

  calc_sequencer #(.W(8)) dut (
    .hz100 (hz100),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model of the external cla8 adder
  assign {bus.add_co, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + 9'(bus.add_ci);

  always #5 hz100 = ~hz100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic exp_t ex(input string n, input logic [7:0] d, input logic c,
                              input logic o, input logic s);
    exp_t e;
    e.name = n; e.disp = d; e.carry = c; e.ovf = o; e.op_sub = s;
    e.chk_add = 1'b0; e.add_a = 8'h00; e.add_b = 8'h00; e.add_ci = 1'b0;
    return e;
  endfunction

  function automatic exp_t exa(input string n, input logic [7:0] d, input logic c,
                               input logic o, input logic s, input logic [7:0] a,
                               input logic [7:0] b, input logic ci);
    exp_t e;
    e = ex(n, d, c, o, s);
    e.chk_add = 1'b1; e.add_a = a; e.add_b = b; e.add_ci = ci;
    return e;
  endfunction

  // Monitor: compares on snapshot requests and on every busy falling edge
  initial begin
    int   snap_seen = 0;
    int   busy_run  = 0;
    logic prev_busy = 1'b0;
    logic fell;
    exp_t e;
    forever begin
      @(negedge hz100);
      fell = prev_busy && !bus.busy;
      if (bus.busy) busy_run++;
      if (fell || snap_cnt != snap_seen) begin
        if (snap_cnt != snap_seen) snap_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'(bus.disp), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check({e.name, " out"}, 64'({bus.disp, bus.carry, bus.ovf, bus.busy, bus.op_sub}),
                64'({e.disp, e.carry, e.ovf, 1'b0, e.op_sub}));
          if (e.chk_add)
            check({e.name, " drive"}, 64'({bus.add_a, bus.add_b, bus.add_ci}),
                  64'({e.add_a, e.add_b, e.add_ci}));
          if (fell) check({e.name, " busy_len"}, 64'(busy_run), 64'd1);
        end
      end
      if (fell) busy_run = 0;
      prev_busy = bus.busy;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic press(input logic [20:0] mask);
    @(negedge hz100);
    bus.pb = mask;
    @(negedge hz100);
    bus.pb = '0;
  endtask

  task automatic key(input int k);
    press(21'b1 << k);
  endtask

  task automatic digits2(input logic [7:0] v);
    key(int'(v[7:4]));
    key(int'(v[3:0]));
  endtask

  task automatic snap(input exp_t e);
    #1;
    exp_q.push_back(e);
    snap_cnt++;
    @(negedge hz100);
    #1;
  endtask

  task automatic do_eq(input exp_t e);
    exp_q.push_back(e);
    key(K_EQ);
    repeat (2) @(negedge hz100);
  endtask

  task automatic operate(input logic [7:0] a, input bit is_sub, input logic [7:0] b,
                         input exp_t e);
    digits2(a);
    key(is_sub ? K_SUB : K_ADD);
    digits2(b);
    do_eq(e);
  endtask

  // Equals followed, during EXEC, by a clear press or a reset pulse
  task automatic eq_interrupt(input bit use_reset, input exp_t e);
    exp_q.push_back(e);
    @(negedge hz100);
    bus.pb = 21'b1 << K_EQ;
    @(negedge hz100);
    bus.pb = '0;
    if (use_reset) reset = 1'b0;
    else bus.pb = 21'b1 << K_CLR;
    @(negedge hz100);
    reset  = 1'b1;
    bus.pb = '0;
    repeat (2) @(negedge hz100);
  endtask

  initial begin
    reset  = 1'b0;
    bus.pb = (21'b1 << 5) | (21'b1 << K_SUB);
    repeat (3) @(negedge hz100);
    snap(exa("in_reset", 8'h00, 0, 0, 0, 8'h00, 8'h00, 0));
    @(negedge hz100);
    reset = 1'b1;
    repeat (3) @(negedge hz100);
    snap(exa("held_through_reset", 8'h00, 0, 0, 0, 8'h00, 8'h00, 0));
    @(negedge hz100);
    bus.pb = '0;
    key(5);
    snap(ex("repress_digit", 8'h05, 0, 0, 0));
    key(K_CLR);
    snap(exa("clear_idle", 8'h00, 0, 0, 0, 8'h00, 8'h00, 0));

    digits2(8'h12);
    key(K_ADD);
    digits2(8'h34);
    snap(exa("entry_b", 8'h34, 0, 0, 0, 8'h12, 8'h00, 0));
    do_eq(ex("add_12_34", 8'h46, 0, 0, 0));
    snap(exa("show_add", 8'h46, 0, 0, 0, 8'h12, 8'h34, 0));

    operate(8'hFF, 0, 8'h01, ex("add_ff_01", 8'h00, 1, 0, 0));
    operate(8'h7F, 0, 8'h01, ex("add_7f_01", 8'h80, 0, 1, 0));
    operate(8'h10, 1, 8'h20, ex("sub_10_20", 8'hF0, 1, 0, 1));
    snap(exa("show_sub", 8'hF0, 1, 0, 1, 8'h10, 8'hDF, 1));
    operate(8'h80, 1, 8'h01, ex("sub_80_01", 8'h7F, 0, 1, 1));

    operate(8'h05, 0, 8'h03, ex("chain_05_03", 8'h08, 0, 0, 0));
    do_eq(ex("repeat_eq", 8'h0B, 0, 0, 0));
    key(K_SUB);
    snap(exa("chain_op", 8'h00, 0, 0, 1, 8'h0B, 8'hFC, 1));
    digits2(8'h01);
    do_eq(ex("chain_sub", 8'h0A, 0, 0, 1));
    key(7);
    snap(ex("show_digit", 8'h07, 0, 0, 1));
    key(1);
    snap(ex("entry_a_shift", 8'h71, 0, 0, 1));

    key(K_CLR);
    key(4);
    press((21'b1 << 3) | (21'b1 << K_ADD));
    snap(exa("simul_entry_a", 8'h00, 0, 0, 0, 8'h04, 8'h00, 0));
    key(5);
    press((21'b1 << 3) | (21'b1 << K_SUB));
    snap(exa("simul_entry_b", 8'h05, 0, 0, 1, 8'h04, 8'hFF, 1));
    do_eq(ex("sub_04_05", 8'hFF, 1, 0, 1));

    digits2(8'h05);
    key(K_SUB);
    digits2(8'h03);
    eq_interrupt(0, exa("clear_in_exec", 8'h00, 0, 0, 0, 8'h00, 8'h00, 0));

    digits2(8'h09);
    key(K_SUB);
    digits2(8'h02);
    eq_interrupt(1, exa("reset_in_exec", 8'h00, 0, 0, 0, 8'h00, 8'h00, 0));

    operate(8'h02, 0, 8'h03, ex("post_reset", 8'h05, 0, 0, 0));

    repeat (3) @(negedge hz100);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("idle_at_end", 64'(bus.busy), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
